// File: rtl/dds_param_loader.sv
// SPI-slave parameter front end for the DDS: shadow writes, atomic commit to active outputs.
// Optional readback of the addressed shadow register on spi_miso: define DDS_PARAM_READBACK_EN.
module dds_param_loader #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [2:0]  DEF_MODE    = 3'd0,
    parameter logic [23:0] DEF_FC      = 24'd0
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [2:0]  mode,
    output logic [23:0] fc,
    output logic [23:0] fs,
    output logic [3:0]  ma,
    output logic [15:0] fd,
    output logic [15:0] pd,
    output logic [15:0] sequenceCode,
    output logic        update_pulse,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t state_r;

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_d_r;
    logic                   cs_d_r;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_rise_s;
    logic                   cs_fall_s;
    logic                   cs_rise_s;

    logic [31:0] shift_r;
    logic [5:0]  bit_cnt_r;
    logic [7:0]  addr_s;
    logic [23:0] data_s;
    logic        frame_ok_s;

    logic [2:0]  mode_sh_r;
    logic [23:0] fc_sh_r;
    logic [23:0] fs_sh_r;
    logic [3:0]  ma_sh_r;
    logic [15:0] fd_sh_r;
    logic [15:0] pd_sh_r;
    logic [15:0] seq_sh_r;

    // Synchroniser chains plus delayed copies for edge detection; the cs_n chain resets low so a
    // select already held low at reset release never looks like a fresh falling edge.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_r  <= '0;
            cs_sync_r   <= '0;
            mosi_sync_r <= '0;
            sck_d_r     <= 1'b0;
            cs_d_r      <= 1'b0;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            sck_d_r     <= sck_s;
            cs_d_r      <= cs_s;
        end
    end

    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign cs_s       = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_d_r;
    assign cs_fall_s  = ~cs_s & cs_d_r;
    assign cs_rise_s  = cs_s & ~cs_d_r;

    assign addr_s     = shift_r[31:24];
    assign data_s     = shift_r[23:0];
    assign frame_ok_s = (bit_cnt_r == 6'd32) && (addr_s <= 8'h07);

    // Frame FSM, shadow registers and active outputs
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            shift_r      <= 32'd0;
            bit_cnt_r    <= 6'd0;
            mode_sh_r    <= DEF_MODE;
            fc_sh_r      <= DEF_FC;
            fs_sh_r      <= 24'd0;
            ma_sh_r      <= 4'd0;
            fd_sh_r      <= 16'd0;
            pd_sh_r      <= 16'd0;
            seq_sh_r     <= 16'd0;
            mode         <= DEF_MODE;
            fc           <= DEF_FC;
            fs           <= 24'd0;
            ma           <= 4'd0;
            fd           <= 16'd0;
            pd           <= 16'd0;
            sequenceCode <= 16'd0;
            update_pulse <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            frame_err    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        bit_cnt_r <= 6'd0;
                        state_r   <= ST_SHIFT;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise_s) begin
                        state_r <= ST_EXEC;
                    end else if (sck_rise_s) begin
                        shift_r <= {shift_r[30:0], mosi_s};
                        if (bit_cnt_r != 6'd63) begin
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r;
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_EXEC: begin
                    state_r <= ST_IDLE;
                    if (frame_ok_s) begin
                        case (addr_s)
                            8'h00: mode_sh_r <= data_s[2:0];
                            8'h01: fc_sh_r   <= data_s;
                            8'h02: fs_sh_r   <= data_s;
                            8'h03: ma_sh_r   <= data_s[3:0];
                            8'h04: fd_sh_r   <= data_s[15:0];
                            8'h05: pd_sh_r   <= data_s[15:0];
                            8'h06: seq_sh_r  <= data_s[15:0];
                            8'h07: begin
                                if (data_s[0]) begin
                                    mode         <= mode_sh_r;
                                    fc           <= fc_sh_r;
                                    fs           <= fs_sh_r;
                                    ma           <= ma_sh_r;
                                    fd           <= fd_sh_r;
                                    pd           <= pd_sh_r;
                                    sequenceCode <= seq_sh_r;
                                    update_pulse <= 1'b1;
                                end else begin
                                    update_pulse <= 1'b0;
                                end
                            end
                            default: frame_err <= 1'b0;
                        endcase
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

`ifdef DDS_PARAM_READBACK_EN
    logic        sck_fall_s;
    logic [7:0]  rd_addr_s;
    logic [23:0] rd_data_s;
    logic        miso_r;
    logic [22:0] tx_sr_r;

    assign sck_fall_s = ~sck_s & sck_d_r;
    assign rd_addr_s  = {shift_r[6:0], mosi_s};

    // Shadow register selected by the address byte completing on this sck edge
    always_comb begin
        rd_data_s = 24'd0;
        case (rd_addr_s)
            8'h00:   rd_data_s = {21'd0, mode_sh_r};
            8'h01:   rd_data_s = fc_sh_r;
            8'h02:   rd_data_s = fs_sh_r;
            8'h03:   rd_data_s = {20'd0, ma_sh_r};
            8'h04:   rd_data_s = {8'd0, fd_sh_r};
            8'h05:   rd_data_s = {8'd0, pd_sh_r};
            8'h06:   rd_data_s = {8'd0, seq_sh_r};
            default: rd_data_s = 24'd0;
        endcase
    end

    // Readback shifter {miso_r, tx_sr_r}; the falling edge right after the load is skipped so
    // the MSB is still on the wire for the first data-phase rising edge.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            miso_r  <= 1'b0;
            tx_sr_r <= 23'd0;
        end else if ((state_r != ST_SHIFT) || cs_rise_s) begin
            miso_r  <= 1'b0;
            tx_sr_r <= 23'd0;
        end else if (sck_rise_s && (bit_cnt_r == 6'd7)) begin
            miso_r  <= rd_data_s[23];
            tx_sr_r <= rd_data_s[22:0];
        end else if (sck_fall_s && (bit_cnt_r >= 6'd9) && (bit_cnt_r <= 6'd32)) begin
            miso_r  <= tx_sr_r[22];
            tx_sr_r <= {tx_sr_r[21:0], 1'b0};
        end else begin
            miso_r  <= miso_r;
            tx_sr_r <= tx_sr_r;
        end
    end

    assign spi_miso = miso_r;
`else
    assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_dds_param_loader.sv
// Table-driven bench for dds_param_loader: SPI frames in, scoreboard of expected pulses/outputs.
module tb_dds_param_loader;

    localparam int SYNC    = 2;
    localparam int HALF    = 8;
    localparam int NV      = 17;
    localparam int RST_IDX = 15;

    logic        clk_100M = 1'b0;
    logic        rst_n    = 1'b0;
    logic        spi_sck  = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [2:0]  mode;
    logic [23:0] fc;
    logic [23:0] fs;
    logic [3:0]  ma;
    logic [15:0] fd;
    logic [15:0] pd;
    logic [15:0] sequenceCode;
    logic        update_pulse;
    logic        frame_err;
    logic [102:0] act_out;

    always #5 clk_100M = ~clk_100M;

    dds_param_loader #(
        .SYNC_STAGES (SYNC),
        .DEF_MODE    (3'd0),
        .DEF_FC      (24'h0A0000)
    ) dut (
        .clk_100M     (clk_100M),
        .rst_n        (rst_n),
        .spi_sck      (spi_sck),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .mode         (mode),
        .fc           (fc),
        .fs           (fs),
        .ma           (ma),
        .fd           (fd),
        .pd           (pd),
        .sequenceCode (sequenceCode),
        .update_pulse (update_pulse),
        .frame_err    (frame_err)
    );

    assign act_out = {mode, fc, fs, ma, fd, pd, sequenceCode};

    typedef struct {
        int          nbits;
        logic [7:0]  addr;
        logic [23:0] data;
        logic        exp_upd;
        logic        exp_err;
        logic [102:0] exp_out;
        logic        rb_chk;
        logic [23:0] exp_rb;
    } vec_t;

    typedef struct {
        logic        exp_upd;
        logic        exp_err;
        logic [102:0] exp_out;
        logic        rb_chk;
        logic [23:0] exp_rb;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[NV];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [102:0] pack(input logic [2:0] m, input logic [23:0] c,
                                          input logic [23:0] s, input logic [3:0] a,
                                          input logic [15:0] d, input logic [15:0] p,
                                          input logic [15:0] q);
        return {m, c, s, a, d, p, q};
    endfunction

    task automatic chk(input string name, input logic [102:0] act, input logic [102:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clock_bit(input logic b, output logic miso_at_rise);
        spi_mosi = b;
        repeat (HALF) @(negedge clk_100M);
        miso_at_rise = spi_miso;
        spi_sck = 1'b1;
        repeat (HALF) @(negedge clk_100M);
        spi_sck = 1'b0;
    endtask

    task automatic send_frame(input int nbits, input logic [31:0] word, output logic [23:0] rb);
        logic m;
        rb = 24'd0;
        @(negedge clk_100M);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk_100M);
        for (int i = 0; i < nbits; i++) begin
            clock_bit(word[31-i], m);
            if (i >= 8 && i < 32) rb[31-i] = m;
        end
        repeat (HALF) @(negedge clk_100M);
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
    endtask

    // Pops the next expectation and observes a fixed window after cs_n rises.
    task automatic watch(input string name, input logic [23:0] rb);
        exp_t        e;
        int          n_upd = 0;
        int          n_err = 0;
        int          first_upd = 0;
        int          both = 0;
        logic [23:0] rb_exp;
        e = sb_q.pop_front();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_100M);
            if (update_pulse) begin
                n_upd++;
                if (first_upd == 0) first_upd = k;
            end
            if (frame_err) n_err++;
            if (update_pulse && frame_err) both++;
        end
        chk({name, " update_pulse cycles"}, 103'(n_upd), 103'(e.exp_upd));
        chk({name, " frame_err cycles"}, 103'(n_err), 103'(e.exp_err));
        chk({name, " pulse overlap"}, 103'(both), 103'd0);
        if (e.exp_upd) chk({name, " commit latency ok"}, 103'(first_upd <= SYNC + 3), 103'd1);
        chk({name, " outputs"}, act_out, e.exp_out);
`ifdef DDS_PARAM_READBACK_EN
        rb_exp = e.exp_rb;
`else
        rb_exp = 24'd0;
`endif
        if (e.rb_chk) chk({name, " readback"}, 103'(rb), 103'(rb_exp));
    endtask

    task automatic push_exp(input logic upd, input logic err, input logic [102:0] out,
                            input logic rbc, input logic [23:0] rbv);
        exp_t e;
        e.exp_upd = upd;
        e.exp_err = err;
        e.exp_out = out;
        e.rb_chk  = rbc;
        e.exp_rb  = rbv;
        sb_q.push_back(e);
    endtask

    initial begin
        logic [102:0] r_out, a_out, b_out, c_out;
        logic [23:0]  rb;
        logic [31:0]  junk;
        logic         m;

        r_out = pack(3'd0, 24'h0A0000, 24'd0, 4'd0, 16'd0, 16'd0, 16'd0);
        a_out = pack(3'd2, 24'h123456, 24'd0, 4'd0, 16'd0, 16'd0, 16'd0);
        b_out = pack(3'd7, 24'h123456, 24'hFEDCBA, 4'h5, 16'hBEEF, 16'h1234, 16'hCAFE);
        c_out = pack(3'd0, 24'h0A0000, 24'd0, 4'hF, 16'd0, 16'd0, 16'd0);

        vecs[0]  = '{32, 8'h01, 24'h123456, 1'b0, 1'b0, r_out, 1'b1, 24'h0A0000};
        vecs[1]  = '{32, 8'h00, 24'h000002, 1'b0, 1'b0, r_out, 1'b1, 24'h000000};
        vecs[2]  = '{32, 8'h07, 24'h000001, 1'b1, 1'b0, a_out, 1'b1, 24'h000000};
        vecs[3]  = '{31, 8'h02, 24'hABCDEF, 1'b0, 1'b1, a_out, 1'b0, 24'h000000};
        vecs[4]  = '{32, 8'h09, 24'h000055, 1'b0, 1'b1, a_out, 1'b1, 24'h000000};
        vecs[5]  = '{32, 8'h07, 24'h000000, 1'b0, 1'b0, a_out, 1'b0, 24'h000000};
        vecs[6]  = '{32, 8'h07, 24'h000001, 1'b1, 1'b0, a_out, 1'b0, 24'h000000};
        vecs[7]  = '{32, 8'h02, 24'hFEDCBA, 1'b0, 1'b0, a_out, 1'b1, 24'h000000};
        vecs[8]  = '{32, 8'h03, 24'hFFFFF5, 1'b0, 1'b0, a_out, 1'b0, 24'h000000};
        vecs[9]  = '{32, 8'h04, 24'h00BEEF, 1'b0, 1'b0, a_out, 1'b0, 24'h000000};
        vecs[10] = '{32, 8'h04, 24'h00BEEF, 1'b0, 1'b0, a_out, 1'b1, 24'h00BEEF};
        vecs[11] = '{32, 8'h05, 24'h001234, 1'b0, 1'b0, a_out, 1'b0, 24'h000000};
        vecs[12] = '{32, 8'h06, 24'h00CAFE, 1'b0, 1'b0, a_out, 1'b0, 24'h000000};
        vecs[13] = '{32, 8'h00, 24'hFFFFF7, 1'b0, 1'b0, a_out, 1'b1, 24'h000002};
        vecs[14] = '{32, 8'h07, 24'h000003, 1'b1, 1'b0, b_out, 1'b0, 24'h000000};
        vecs[15] = '{32, 8'h03, 24'h00000F, 1'b0, 1'b0, r_out, 1'b0, 24'h000000};
        vecs[16] = '{32, 8'h07, 24'h000001, 1'b1, 1'b0, c_out, 1'b0, 24'h000000};

        repeat (4) @(negedge clk_100M);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_100M);
        chk("reset outputs", act_out, r_out);
        chk("reset update_pulse", 103'(update_pulse), 103'd0);
        chk("reset frame_err", 103'(frame_err), 103'd0);
        chk("reset spi_miso", 103'(spi_miso), 103'd0);

        for (int i = 0; i < NV; i++) begin
            if (i == RST_IDX) begin
                // Reset lands mid-frame while cs_n stays low; the remainder must be ignored.
                junk = {8'h02, 24'hABCDEF};
                @(negedge clk_100M);
                spi_cs_n = 1'b0;
                repeat (HALF) @(negedge clk_100M);
                for (int j = 0; j < 20; j++) clock_bit(junk[31-j], m);
                rst_n = 1'b0;
                repeat (3) @(negedge clk_100M);
                chk("in-reset outputs", act_out, r_out);
                rst_n = 1'b1;
                for (int j = 20; j < 32; j++) clock_bit(junk[31-j], m);
                repeat (HALF) @(negedge clk_100M);
                spi_cs_n = 1'b1;
                push_exp(1'b0, 1'b0, r_out, 1'b0, 24'd0);
                watch("aborted frame", 24'd0);
                // sck/mosi activity with cs_n high must be ignored.
                for (int j = 0; j < 40; j++) begin
                    spi_mosi = 1'($urandom_range(0, 1));
                    repeat (HALF) @(negedge clk_100M);
                    spi_sck = ~spi_sck;
                end
                spi_sck = 1'b0;
                push_exp(1'b0, 1'b0, r_out, 1'b0, 24'd0);
                watch("sck with cs high", 24'd0);
            end
            push_exp(vecs[i].exp_upd, vecs[i].exp_err, vecs[i].exp_out,
                     vecs[i].rb_chk, vecs[i].exp_rb);
            send_frame(vecs[i].nbits, {vecs[i].addr, vecs[i].data}, rb);
            watch($sformatf("vec%0d", i), rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
